// File: rtl/instruction_fetch.sv
// Instruction fetch unit: keeps the PC, issues one-word reads over a req/ack
// handshake and queues {pc, instruction} pairs toward decode. Redirects flush
// the queue; a response still in flight is drained and thrown away first.
module instruction_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_IMem_Req,
    output logic [XLEN-1:0] o_IMem_Addr,
    input  logic            i_IMem_Ack,
    input  logic [31:0]     i_IMem_Data,
    output logic            o_Valid,
    output logic [31:0]     o_Instruction,
    output logic [XLEN-1:0] o_PC,
    input  logic            i_Ready,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_Redirect_PC,
    output logic            o_Misaligned
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, FAULT} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
    logic            pend_fault_reg, pend_fault_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [PW-1:0]   head_reg, head_next;
    logic [PW-1:0]   tail_reg, tail_next;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic push;
    logic pop;
    logic target_misaligned;

    // A redirect cancels both the pop and any push in the same cycle.
    assign push = (state_reg == REQ) && i_IMem_Ack && !i_Redirect;
    assign pop  = o_Valid && i_Ready && !i_Redirect;
    assign target_misaligned = (i_Redirect_PC[1:0] != 2'b00);

    // Memory-side outputs come only from registered state, never from inputs.
    assign o_IMem_Req    = (state_reg == REQ) || (state_reg == DISCARD);
    assign o_IMem_Addr   = pc_reg;
    assign o_Valid       = (count_reg != '0);
    assign o_Instruction = instr_mem[head_reg];
    assign o_PC          = pc_mem[head_reg];
    assign o_Misaligned  = (state_reg == FAULT);

    // One write enable per queue slot, selected by the tail pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (tail_reg == PW'(gi));
        end
    endgenerate

    // Next-state, PC and queue-pointer decode; redirect overrides everything.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_pc_next    = pend_pc_reg;
        pend_fault_next = pend_fault_reg;
        count_next      = count_reg + CW'(push) - CW'(pop);
        head_next       = head_reg + PW'(pop);
        tail_next       = tail_reg + PW'(push);

        if (i_Redirect) begin
            count_next = '0;
            head_next  = '0;
            tail_next  = '0;
            if (((state_reg == REQ) || (state_reg == DISCARD)) && !i_IMem_Ack) begin
                // Request still open: drain it before going anywhere.
                state_next      = DISCARD;
                pend_pc_next    = i_Redirect_PC;
                pend_fault_next = target_misaligned;
            end else if (target_misaligned) begin
                state_next = FAULT;
            end else begin
                pc_next    = i_Redirect_PC;
                state_next = REQ;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (count_next < DEPTH_C) state_next = REQ;
                end
                REQ: begin
                    if (i_IMem_Ack) begin
                        pc_next = pc_reg + XLEN'(4);
                        if (!(count_next < DEPTH_C)) state_next = IDLE;
                    end
                end
                DISCARD: begin
                    if (i_IMem_Ack) begin
                        if (pend_fault_reg) begin
                            state_next = FAULT;
                        end else begin
                            pc_next    = pend_pc_reg;
                            state_next = REQ;
                        end
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            pend_pc_reg    <= RESET_PC;
            pend_fault_reg <= 1'b0;
            count_reg      <= '0;
            head_reg       <= '0;
            tail_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_pc_reg    <= pend_pc_next;
            pend_fault_reg <= pend_fault_next;
            count_reg      <= count_next;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
        end
    end

    // Queue storage: capture the returned word with the PC it was fetched from.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    instr_mem[i] <= i_IMem_Data;
                    pc_mem[i]    <= pc_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for sequential fetch,
// back-pressure and slow memory, then hand-written redirect/fault/wrap cases.
module tb_instruction_fetch;

    localparam logic [31:0] MAGIC = 32'h1357_9BDF;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int n_checks;
    int n_fail;

    instruction_fetch #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_IMem_Req   (imem_req),
        .o_IMem_Addr  (imem_addr),
        .i_IMem_Ack   (imem_ack),
        .i_IMem_Data  (imem_data),
        .o_Valid      (valid),
        .o_Instruction(instruction),
        .o_PC         (pc),
        .i_Ready      (ready),
        .i_Redirect   (redirect),
        .i_Redirect_PC(redirect_pc),
        .o_Misaligned (misaligned)
    );

    // Memory returns a word derived from its address so every PC is traceable.
    assign imem_data = imem_addr ^ MAGIC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge), check outputs,
    // then advance to the next negedge.
    task automatic step(input string name, input logic redir, input logic [31:0] rpc,
                        input logic rdy, input logic ack,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input logic exp_valid, input logic [31:0] exp_pc,
                        input logic exp_mis);
        redirect    = redir;
        redirect_pc = rpc;
        ready       = rdy;
        imem_ack    = ack;
        #1;
        $display("%s: req=%0b addr=%h valid=%0b pc=%h instr=%h mis=%0b",
                 name, imem_req, imem_addr, valid, pc, instruction, misaligned);
        cmp({name, ".req"}, {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) cmp({name, ".addr"}, imem_addr, exp_addr);
        cmp({name, ".valid"}, {31'b0, valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            cmp({name, ".pc"}, pc, exp_pc);
            cmp({name, ".instr"}, instruction, exp_pc ^ MAGIC);
        end
        cmp({name, ".mis"}, {31'b0, misaligned}, {31'b0, exp_mis});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        imem_ack    = 1'b0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        //            rdy   ack   req   addr          valid pc
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0014};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h0000_0018, 1'b0, 32'h0000_0000};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h0000_0018, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b0, 32'h0000_0000};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0018};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_001C};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_001C};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        cmp("rst.req",   {31'b0, imem_req},   32'd0);
        cmp("rst.addr",  imem_addr,           32'h0000_0000);
        cmp("rst.valid", {31'b0, valid},      32'd0);
        cmp("rst.instr", instruction,         32'd0);
        cmp("rst.pc",    pc,                  32'd0);
        cmp("rst.mis",   {31'b0, misaligned}, 32'd0);
        rst = 1'b0;

        // Sequential fetch, back-pressure to a full queue, slow memory.
        for (int i = 0; i < NV; i++) begin
            step($sformatf("vec%0d", i), 1'b0, 32'h0, vecs[i].rdy, vecs[i].ack,
                 vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc, 1'b0);
        end

        // Redirect while 0x20 is outstanding: drained, dropped, then 0x100.
        step("rd_issue", 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h1C, 1'b0);
        step("rd_wait",  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20,  1'b0, 32'h0, 1'b0);
        step("rd_drain", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h20,  1'b0, 32'h0, 1'b0);
        step("rd_new",   1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        step("rd_first", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0);
        step("rd_next",  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 32'h104, 1'b0);

        // Misaligned redirect with a same-cycle ack: straight to fault.
        step("mis_issue", 1'b1, 32'h0000_0102, 1'b1, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("fault%0d", i), 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        step("fault_exit", 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("resume0",    1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);

        // Misaligned redirect while a request is open: drain first, then fault.
        step("mis2_issue", 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'h204, 1'b1, 32'h200, 1'b0);
        step("mis2_wait",  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0);
        step("mis2_drain", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0);
        step("mis2_fault", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 1'b1);

        // PC wrap from the top of the address space.
        step("wrap_rd", 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step("wrap0",   1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0);
        step("wrap1",   1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 1'b0);
        step("wrap2",   1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0);

        // Redirect coincident with pop and ack: acked word 0x4 is dropped.
        step("co_issue", 1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
        step("co_new",   1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        step("co_first", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 32'h40, 1'b0);

        // Asynchronous reset in the middle of an open request.
        rst = 1'b1;
        #1;
        cmp("mrst.req",   {31'b0, imem_req}, 32'd0);
        cmp("mrst.addr",  imem_addr,         32'h0000_0000);
        cmp("mrst.valid", {31'b0, valid},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst0", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step("post_rst1", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
